// File: rtl/result_bias_relu_buffer_if.sv
`default_nettype none
// ============================================================================
// Module      : result_bias_relu_buffer_if
// Description : Bundles the bias-load, result-capture and drain handshake
//               signals of result_bias_relu_buffer.
//               master : upstream/downstream environment (drives bias_*,
//                        relu_en, in_*, out_ready; observes out_*, busy,
//                        drop_err)
//               slave  : the buffer itself
// Revision    : 1.0 - initial release
// ============================================================================
interface result_bias_relu_buffer_if #(
    parameter int DATA_WIDTH = 16,
    parameter int M          = 4,
    parameter int N          = 2
);
    localparam int c_ROW_W = (M > 1) ? $clog2(M) : 1;
    localparam int c_COL_W = (N > 1) ? $clog2(N) : 1;

    logic signed [DATA_WIDTH-1:0] bias_data;
    logic        [c_COL_W-1:0]    bias_col;
    logic                         bias_valid;
    logic                         relu_en;
    logic signed [DATA_WIDTH-1:0] in_data;
    logic        [c_ROW_W-1:0]    in_row;
    logic        [c_COL_W-1:0]    in_col;
    logic                         in_valid;
    logic signed [DATA_WIDTH-1:0] out_data;
    logic        [c_ROW_W-1:0]    out_row;
    logic        [c_COL_W-1:0]    out_col;
    logic                         out_valid;
    logic                         out_ready;
    logic                         out_last;
    logic                         busy;
    logic                         drop_err;

    modport master (
        output bias_data, bias_col, bias_valid, relu_en,
        output in_data, in_row, in_col, in_valid,
        output out_ready,
        input  out_data, out_row, out_col, out_valid, out_last,
        input  busy, drop_err
    );

    modport slave (
        input  bias_data, bias_col, bias_valid, relu_en,
        input  in_data, in_row, in_col, in_valid,
        input  out_ready,
        output out_data, out_row, out_col, out_valid, out_last,
        output busy, drop_err
    );
endinterface
`default_nettype wire

// File: rtl/result_bias_relu_buffer.sv
`default_nettype none
// ============================================================================
// Module      : result_bias_relu_buffer
// Description : Captures an M x N result tile (any arrival order), adds a
//               per-column bias with saturation, optionally clamps negatives
//               to zero, then drains the tile row-major over valid/ready.
// Ports       : clk  - rising-edge clock
//               rst  - synchronous active-high reset
//               bus  - slave side of result_bias_relu_buffer_if
//                      (bias load, element capture, drain stream, status)
// Revision    : 1.0 - initial release
// ============================================================================
module result_bias_relu_buffer #(
    parameter int DATA_WIDTH = 16,
    parameter int FRAC_WIDTH = 8,
    parameter int M          = 4,
    parameter int N          = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    result_bias_relu_buffer_if.slave  bus
);
    localparam int c_ROW_W = (M > 1) ? $clog2(M) : 1;
    localparam int c_COL_W = (N > 1) ? $clog2(N) : 1;
    localparam int c_IDX_W = (M * N > 1) ? $clog2(M * N) : 1;
    localparam int c_PTR_W = $clog2(M * N + 1);

    localparam logic [0:0] c_ST_COLLECT = 1'b0;
    localparam logic [0:0] c_ST_DRAIN   = 1'b1;

    localparam logic signed [DATA_WIDTH-1:0] c_SAT_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [DATA_WIDTH-1:0] c_SAT_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    // Bias and data share one fixed-point format, so the fraction width only
    // has to leave room for at least one integer (sign) bit.
    generate
        if (FRAC_WIDTH >= DATA_WIDTH) begin : g_frac_check
            $error("FRAC_WIDTH must be smaller than DATA_WIDTH");
        end
    endgenerate

    logic [0:0]                   r_state;
    logic [0:0]                   w_next_state;
    logic signed [DATA_WIDTH-1:0] r_bias [N];
    logic signed [DATA_WIDTH-1:0] r_buf  [M*N];
    logic [M*N-1:0]               r_filled;
    logic [c_PTR_W-1:0]           r_count;
    logic [c_PTR_W-1:0]           r_rd_ptr;

    logic signed [DATA_WIDTH-1:0] r_out_data;
    logic [c_ROW_W-1:0]           r_out_row;
    logic [c_COL_W-1:0]           r_out_col;
    logic                         r_out_valid;
    logic                         r_out_last;
    logic                         r_busy;
    logic                         r_drop_err;

    logic [c_IDX_W-1:0]           w_wr_idx;
    logic                         w_new_loc;
    logic signed [DATA_WIDTH:0]   w_sum;
    logic signed [DATA_WIDTH-1:0] w_sat;
    logic signed [DATA_WIDTH-1:0] w_result;
    logic                         w_capture;
    logic                         w_bias_wr;
    logic                         w_drop;
    logic                         w_load;
    logic                         w_last_hs;

    // ---------------------------------------------------------------- datapath
    assign w_wr_idx  = c_IDX_W'(int'(bus.in_row) * N + int'(bus.in_col));
    assign w_new_loc = ~r_filled[w_wr_idx];
    // One extra bit so the sum can never wrap before saturation.
    assign w_sum     = {bus.in_data[DATA_WIDTH-1], bus.in_data}
                     + {r_bias[bus.in_col][DATA_WIDTH-1], r_bias[bus.in_col]};

    always_comb begin
        w_sat = w_sum[DATA_WIDTH-1:0];
        // Top two bits disagree only when the sum left the representable range.
        if (w_sum[DATA_WIDTH] != w_sum[DATA_WIDTH-1]) begin
            w_sat = w_sum[DATA_WIDTH] ? c_SAT_MIN : c_SAT_MAX;
        end
        w_result = (bus.relu_en && w_sat[DATA_WIDTH-1]) ? '0 : w_sat;
    end

    // ---------------------------------------------------------- state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_COLLECT;
        end else begin
            r_state <= w_next_state;
        end
    end

    // -------------------------------------------------------------- next state
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_ST_COLLECT: begin
                // The write that fills the last empty slot triggers the drain.
                if (w_capture && w_new_loc && (r_count == c_PTR_W'(M * N - 1))) begin
                    w_next_state = c_ST_DRAIN;
                end
            end
            c_ST_DRAIN: begin
                if (w_last_hs) begin
                    w_next_state = c_ST_COLLECT;
                end
            end
            default: w_next_state = c_ST_COLLECT;
        endcase
    end

    // ---------------------------------------------------------- output decode
    always_comb begin
        w_capture = 1'b0;
        w_bias_wr = 1'b0;
        w_drop    = 1'b0;
        w_load    = 1'b0;
        w_last_hs = 1'b0;
        case (r_state)
            c_ST_COLLECT: begin
                w_capture = bus.in_valid;
                w_bias_wr = bus.bias_valid;
            end
            c_ST_DRAIN: begin
                w_drop    = bus.in_valid | bus.bias_valid;
                // Refill the output register whenever it is empty or being taken.
                w_load    = (r_rd_ptr != c_PTR_W'(M * N)) && (!r_out_valid || bus.out_ready);
                w_last_hs = r_out_valid && bus.out_ready && r_out_last;
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------- control / status
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                r_bias[i] <= '0;
            end
            r_filled    <= '0;
            r_count     <= '0;
            r_rd_ptr    <= '0;
            r_out_data  <= '0;
            r_out_row   <= '0;
            r_out_col   <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_busy      <= 1'b0;
            r_drop_err  <= 1'b0;
        end else begin
            if (w_bias_wr) begin
                r_bias[bus.bias_col] <= bus.bias_data;
            end
            if (w_capture) begin
                r_filled[w_wr_idx] <= 1'b1;
                if (w_new_loc) begin
                    r_count <= r_count + 1'b1;
                end
            end
            if (w_drop) begin
                r_drop_err <= 1'b1;
            end
            if (w_last_hs) begin
                r_filled <= '0;
                r_count  <= '0;
                r_rd_ptr <= '0;
            end
            if (w_load) begin
                r_out_data  <= r_buf[r_rd_ptr[c_IDX_W-1:0]];
                r_out_row   <= c_ROW_W'(int'(r_rd_ptr) / N);
                r_out_col   <= c_COL_W'(int'(r_rd_ptr) % N);
                r_out_last  <= (r_rd_ptr == c_PTR_W'(M * N - 1));
                r_out_valid <= 1'b1;
                r_busy      <= 1'b1;
                r_rd_ptr    <= r_rd_ptr + 1'b1;
            end else if (r_out_valid && bus.out_ready) begin
                r_out_valid <= 1'b0;
                r_out_last  <= 1'b0;
                r_busy      <= 1'b0;
            end
        end
    end

    // Tile storage needs no reset: every slot is written before it is drained.
    always_ff @(posedge clk) begin
        if (w_capture) begin
            r_buf[w_wr_idx] <= w_result;
        end
    end

    assign bus.out_data  = r_out_data;
    assign bus.out_row   = r_out_row;
    assign bus.out_col   = r_out_col;
    assign bus.out_valid = r_out_valid;
    assign bus.out_last  = r_out_last;
    assign bus.busy      = r_busy;
    assign bus.drop_err  = r_drop_err;

endmodule
`default_nettype wire
